dp_ram_bytewrite: RTL and testbench

Parametrised true dual-port synchronous RAM. It succeeds the basic 8-bit dual-port RAM and adds:
- per-port enables and byte-lane write enables
- selectable read-during-write mode and optional output pipeline register
- read-valid strobes and same-address collision detection/arbitration
- a post-reset memory-clear sequencer
Used as the shared scratch/buffer memory between two independent masters on one clock.

---
 rtl/dp_ram_pkg.sv | 17 +
 rtl/dp_ram_out_stage.sv | 51 +++++
 rtl/dp_ram_bytewrite.sv | 109 ++++++++++
 tb/tb_dp_ram_bytewrite.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-writable dual-port RAM.
// Read-during-write mode constants and the byte-lane count derivation live here.
package dp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  function automatic int calcNb(input int dataWidth, input int byteWidth);
    return dataWidth / byteWidth;
  endfunction

endpackage

// File: rtl/dp_ram_out_stage.sv
// Per-port read data/valid pipeline: one mandatory register stage plus an optional second one.
// Data holds its last value when no valid read passes through a stage.
module dp_ram_out_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid1;
  logic [DATA_WIDTH-1:0] r_data1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid1 <= 1'b0;
      r_data1  <= '0;
    end else begin
      r_valid1 <= i_valid;
      if (i_valid) r_data1 <= i_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_outReg
      logic                  r_valid2;
      logic [DATA_WIDTH-1:0] r_data2;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid2 <= 1'b0;
          r_data2  <= '0;
        end else begin
          r_valid2 <= r_valid1;
          if (r_valid1) r_data2 <= r_data1;
        end
      end

      assign o_valid = r_valid2;
      assign o_data  = r_data2;
    end else begin : g_noOutReg
      assign o_valid = r_valid1;
      assign o_data  = r_data1;
    end
  endgenerate

endmodule

// File: rtl/dp_ram_bytewrite.sv
// True dual-port RAM with byte-lane writes, post-reset clear sequencer and same-address
// collision arbitration (port A wins lanes written by both ports).
module dp_ram_bytewrite
  import dp_ram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 4,
  parameter  int BYTE_WIDTH = 8,
  parameter  int READ_MODE  = 0,
  parameter  int OUT_REG    = 0,
  localparam int NB         = calcNb(DATA_WIDTH, BYTE_WIDTH),
  localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic [NB-1:0]         we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic [NB-1:0]         we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  valid_b,
  output logic                  busy,
  output logic                  collision
);

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_clearPtr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_collision;

  logic                  w_accA, w_accB;
  logic [DATA_WIDTH-1:0] w_oldA, w_oldB, w_mergeA, w_mergeB, w_rdA, w_rdB;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clearPtr <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == CLEAR) r_clearPtr <= r_clearPtr + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      CLEAR:   if (r_clearPtr == ADDR_WIDTH'(DEPTH - 1)) w_nextState = READY;
      default: w_nextState = r_state;
    endcase
  end

  assign busy   = (r_state == CLEAR);
  assign w_accA = en_a && !rst && (r_state == READY);
  assign w_accB = en_b && !rst && (r_state == READY);
  assign w_oldA = r_mem[addr_a];
  assign w_oldB = r_mem[addr_b];

  // Each port's own lanes merged over the old word; only used in write-first mode.
  always_comb begin
    w_mergeA = w_oldA;
    w_mergeB = w_oldB;
    for (int i = 0; i < NB; i++) begin
      if (we_a[i]) w_mergeA[i*BYTE_WIDTH +: BYTE_WIDTH] = din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (we_b[i]) w_mergeB[i*BYTE_WIDTH +: BYTE_WIDTH] = din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign w_rdA = (READ_MODE == WRITE_FIRST) ? w_mergeA : w_oldA;
  assign w_rdB = (READ_MODE == WRITE_FIRST) ? w_mergeB : w_oldB;

  // Port B lanes are written before port A so A overrides B on shared lanes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) begin
        r_mem[r_clearPtr] <= '0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (w_accB && we_b[i])
            r_mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
          if (w_accA && we_a[i])
            r_mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_collision <= 1'b0;
    else     r_collision <= w_accA && w_accB && (addr_a == addr_b) && ((|we_a) || (|we_b));
  end

  assign collision = r_collision;

  dp_ram_out_stage #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_outA (
    .clk(clk), .rst(rst), .i_valid(w_accA), .i_data(w_rdA), .o_valid(valid_a), .o_data(dout_a)
  );

  dp_ram_out_stage #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_outB (
    .clk(clk), .rst(rst), .i_valid(w_accB), .i_data(w_rdB), .o_valid(valid_b), .o_data(dout_b)
  );

endmodule

// File: tb/tb_dp_ram_bytewrite.sv
// Bench for dp_ram_bytewrite: two instances (read-first/no out reg, write-first/out reg)
// share stimulus and are compared every cycle against a word-level memory model.
module tb_dp_ram_bytewrite;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [3:0]  we_a = '0, we_b = '0;
  logic [3:0]  addr_a = '0, addr_b = '0;
  logic [31:0] din_a = '0, din_b = '0;

  logic [31:0] doutA0, doutB0, doutA1, doutB1;
  logic        validA0, validB0, validA1, validB1;
  logic        busy0, busy1, coll0, coll1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dp_ram_bytewrite #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(doutA0), .valid_a(validA0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(doutB0), .valid_b(validB0),
    .busy(busy0), .collision(coll0)
  );

  dp_ram_bytewrite #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(doutA1), .valid_a(validA1),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(doutB1), .valid_b(validB1),
    .busy(busy1), .collision(coll1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] din,
                                            input logic [3:0] we);
    logic [31:0] w;
    w = old;
    for (int i = 0; i < 4; i++) if (we[i]) w[i*8 +: 8] = din[i*8 +: 8];
    return w;
  endfunction

  // Reference model: a 16-word array, a busy countdown and per-instance expected outputs.
  logic [31:0] memModel [16];
  int          busyLeft = 0;
  bit          modelOn = 1'b0;
  logic [31:0] eDoutA0, eDoutB0, eDoutA1, eDoutB1, pDoutA1, pDoutB1;
  bit          eValA0, eValB0, eValA1, eValB1, pValA1, pValB1, eColl, eBusy;

  always @(posedge clk) begin
    bit          accA, accB;
    logic [31:0] oldA, oldB;
    if (rst) begin
      modelOn  = 1'b1;
      busyLeft = 16;
      eDoutA0 = '0; eDoutB0 = '0; eDoutA1 = '0; eDoutB1 = '0; pDoutA1 = '0; pDoutB1 = '0;
      eValA0 = 0; eValB0 = 0; eValA1 = 0; eValB1 = 0; pValA1 = 0; pValB1 = 0; eColl = 0;
      for (int i = 0; i < 16; i++) memModel[i] = '0;
    end else begin
      accA  = en_a && (busyLeft == 0);
      accB  = en_b && (busyLeft == 0);
      oldA  = memModel[addr_a];
      oldB  = memModel[addr_b];
      eColl = accA && accB && (addr_a == addr_b) && ((we_a != 0) || (we_b != 0));
      eValA1 = pValA1; if (pValA1) eDoutA1 = pDoutA1;
      eValB1 = pValB1; if (pValB1) eDoutB1 = pDoutB1;
      pValA1 = accA;   if (accA) pDoutA1 = mergeWord(oldA, din_a, we_a);
      pValB1 = accB;   if (accB) pDoutB1 = mergeWord(oldB, din_b, we_b);
      eValA0 = accA;   if (accA) eDoutA0 = oldA;
      eValB0 = accB;   if (accB) eDoutB0 = oldB;
      if (accB) memModel[addr_b] = mergeWord(memModel[addr_b], din_b, we_b);
      if (accA) memModel[addr_a] = mergeWord(memModel[addr_a], din_a, we_a);
      if (busyLeft > 0) busyLeft--;
    end
    eBusy = (busyLeft > 0);
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("busy0", 32'(busy0), 32'(eBusy));
      checkOutput("busy1", 32'(busy1), 32'(eBusy));
      checkOutput("coll0", 32'(coll0), 32'(eColl));
      checkOutput("coll1", 32'(coll1), 32'(eColl));
      checkOutput("validA0", 32'(validA0), 32'(eValA0));
      checkOutput("validB0", 32'(validB0), 32'(eValB0));
      checkOutput("validA1", 32'(validA1), 32'(eValA1));
      checkOutput("validB1", 32'(validB1), 32'(eValB1));
      checkOutput("doutA0", doutA0, eDoutA0);
      checkOutput("doutB0", doutB0, eDoutB0);
      checkOutput("doutA1", doutA1, eDoutA1);
      checkOutput("doutB1", doutB1, eDoutB1);
    end
  end

  // One accepted cycle on the given ports; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input bit enA, input logic [3:0] weA, input logic [3:0] adA,
                               input logic [31:0] dA, input bit enB, input logic [3:0] weB,
                               input logic [3:0] adB, input logic [31:0] dB);
    @(negedge clk);
    en_a = enA; we_a = weA; addr_a = adA; din_a = dA;
    en_b = enB; we_b = weB; addr_b = adB; din_b = dB;
    @(negedge clk);
    en_a = 1'b0; we_a = '0; en_b = 1'b0; we_b = '0;
  endtask

  // Counts busy cycles (bounded); optionally fires port A writes to addr 0 while busy.
  task automatic waitReady(input bit drive, output int n);
    n = 0;
    while (busy0 && n < 200) begin
      if (drive) begin
        en_a = 1'b1; we_a = 4'hF; addr_a = 4'd0; din_a = 32'hFFFF_FFFF;
        checkOutput("busyNoValidA0", 32'(validA0), 32'd0);
        checkOutput("busyNoValidA1", 32'(validA1), 32'd0);
      end
      @(negedge clk);
      n++;
    end
    en_a = 1'b0; we_a = '0;
  endtask

  initial begin
    int n;
    $display("[TB] start");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    waitReady(1'b0, n);
    checkOutput("initialClearCycles", 32'(n), 32'd16);

    // Clear wipes a preloaded word
    applyStimulus(1, 4'hF, 4'd5, 32'hDEAD_BEEF, 0, 4'h0, 4'd0, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    waitReady(1'b0, n);
    checkOutput("resetClearCycles", 32'(n), 32'd16);
    applyStimulus(1, 4'h0, 4'd5, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    checkOutput("clearedWord", doutA0, 32'h0000_0000);
    checkOutput("clearedValid", 32'(validA0), 32'd1);

    // Byte-lane write and two-cycle latency of the registered instance
    applyStimulus(1, 4'hF, 4'd3, 32'h1122_3344, 0, 4'h0, 4'd0, 32'h0);
    applyStimulus(1, 4'b0101, 4'd3, 32'hAABB_CCDD, 0, 4'h0, 4'd0, 32'h0);
    applyStimulus(1, 4'h0, 4'd3, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    checkOutput("byteMerge0", doutA0, 32'h11BB_33DD);
    checkOutput("latency1Valid1Low", 32'(validA1), 32'd0);
    @(negedge clk);
    checkOutput("byteMerge1", doutA1, 32'h11BB_33DD);
    checkOutput("latency2Valid1High", 32'(validA1), 32'd1);

    // Read-during-write on the same port
    applyStimulus(1, 4'hF, 4'd7, 32'h1234_5678, 0, 4'h0, 4'd0, 32'h0);
    applyStimulus(1, 4'hF, 4'd7, 32'hCAFE_F00D, 0, 4'h0, 4'd0, 32'h0);
    checkOutput("readFirst", doutA0, 32'h1234_5678);
    @(negedge clk);
    checkOutput("writeFirst", doutA1, 32'hCAFE_F00D);

    // Write/write collision, A wins shared lanes
    applyStimulus(1, 4'b0011, 4'd2, 32'h0000_00AA, 1, 4'hF, 4'd2, 32'hBBBB_BBBB);
    checkOutput("wwCollision0", 32'(coll0), 32'd1);
    checkOutput("wwCollision1", 32'(coll1), 32'd1);
    @(negedge clk);
    checkOutput("wwCollisionPulse", 32'(coll0), 32'd0);
    applyStimulus(0, 4'h0, 4'd0, 32'h0, 1, 4'h0, 4'd2, 32'h0);
    checkOutput("wwMerged", doutB0, 32'hBBBB_00AA);

    // Read/write collision, reader sees the old word
    applyStimulus(1, 4'hF, 4'd9, 32'h0000_0055, 0, 4'h0, 4'd0, 32'h0);
    applyStimulus(1, 4'h0, 4'd9, 32'h0, 1, 4'hF, 4'd9, 32'h0000_0066);
    checkOutput("rwOld0", doutA0, 32'h0000_0055);
    checkOutput("rwCollision", 32'(coll0), 32'd1);
    @(negedge clk);
    checkOutput("rwOld1", doutA1, 32'h0000_0055);
    applyStimulus(1, 4'h0, 4'd9, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    checkOutput("rwNew", doutA0, 32'h0000_0066);

    // Reset mid-clear restarts the full clear; busy-time requests are dropped
    applyStimulus(1, 4'hF, 4'd0, 32'h1357_9BDF, 0, 4'h0, 4'd0, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    waitReady(1'b1, n);
    checkOutput("midClearRestartCycles", 32'(n), 32'd16);
    applyStimulus(1, 4'h0, 4'd0, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    checkOutput("droppedWrite0", doutA0, 32'h0);
    @(negedge clk);
    checkOutput("droppedWrite1", doutA1, 32'h0);

    // Randomised traffic with biased address overlap and rare resets
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 249) == 0);
      en_a   = ($urandom_range(0, 3) != 0);
      en_b   = ($urandom_range(0, 3) != 0);
      we_a   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      we_b   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      addr_a = 4'($urandom_range(0, 15));
      addr_b = ($urandom_range(0, 2) == 0) ? addr_a : 4'($urandom_range(0, 15));
      din_a  = $urandom;
      din_b  = $urandom;
    end
    @(negedge clk);
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
